ltc1406_capture_ctrl: RTL and testbench

Sequences the LTC1406 ADC front end: powers the converter up, waits out its wake-up time, discards the settling samples, then captures bursts of a requested length. Samples go to the DSP chain over a valid/ready port. Sits between the ADC driver (`ltc1406_adc_driver_sv`, whose active-high `i_rst` it drives) and the downstream mixer/decimator. Samples that arrive while the output is stalled are dropped and counted; the controller never stalls the ADC.

---
 rtl/ltc1406_capture_ctrl.sv | 159 +++++++++++++++
 tb/tb_ltc1406_capture_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc1406_capture_ctrl.sv
// LTC1406 front-end sequencer: power-up, wake wait, settle discard, then
// length-limited capture bursts onto a valid/ready sample port.
module ltc1406_capture_ctrl #(
  parameter int ENOB           = 7,
  parameter int WAKE_CYCLES    = 400,
  parameter int SETTLE_SAMPLES = 4,
  parameter int LEN_W          = 16
) (
  input  logic             i_sysclk_40,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic             o_adc_rst,
  input  logic [ENOB-1:0]  i_adc_data,
  input  logic             i_adc_dv,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic [ENOB-1:0]  o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_adc_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_overrun_cnt,
  output logic [2:0]       o_dbg_state
);

  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam int SET_W  = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_SAMPLES);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_WAKE    = 3'd1,
    S_SETTLE  = 3'd2,
    S_IDLE    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [WAKE_W-1:0]  wake_q, wake_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [ENOB-1:0]    data_d;
  logic               valid_d;
  logic               done_d;
  logic [7:0]         ovr_d;
  logic               can_load;

  // Output port is a one-deep register: a beat transfers when o_valid && i_ready
  // are both high at a clock edge; o_valid never depends on i_ready combinationally.
  // A new sample may enter whenever the register is empty or is being emptied.
  assign can_load    = !o_valid || i_ready;
  assign o_dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    wake_d   = wake_q;
    settle_d = settle_q;
    rem_d    = rem_q;
    data_d   = o_data;
    valid_d  = o_valid && !i_ready;
    done_d   = 1'b0;
    ovr_d    = o_overrun_cnt;

    if (state_q != S_OFF && !i_enable) begin
      state_d = S_OFF;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (i_enable) begin
            state_d = S_WAKE;
            wake_d  = WAKE_LOAD;
          end
        end
        S_WAKE: begin
          if (wake_q == '0) begin
            if (SETTLE_SAMPLES == 0) begin
              state_d = S_IDLE;
            end else begin
              state_d  = S_SETTLE;
              settle_d = SET_LOAD;
            end
          end else begin
            wake_d = wake_q - 1'b1;
          end
        end
        S_SETTLE: begin
          if (i_adc_dv) begin
            settle_d = settle_q - 1'b1;
            if (settle_q == SET_W'(1)) state_d = S_IDLE;
          end
        end
        S_IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_CAPTURE;
              rem_d   = i_len;
              ovr_d   = '0;
            end
          end
        end
        S_CAPTURE: begin
          if (i_adc_dv) begin
            rem_d = rem_q - 1'b1;
            if (can_load) begin
              data_d  = i_adc_data;
              valid_d = 1'b1;
            end else if (o_overrun_cnt != 8'hFF) begin
              ovr_d = o_overrun_cnt + 8'd1;
            end
            if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (can_load) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_sysclk_40) begin
    if (!i_rst_n) begin
      state_q       <= S_OFF;
      wake_q        <= '0;
      settle_q      <= '0;
      rem_q         <= '0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_done        <= 1'b0;
      o_overrun_cnt <= '0;
      o_adc_rst     <= 1'b1;
      o_adc_ready   <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wake_q        <= wake_d;
      settle_q      <= settle_d;
      rem_q         <= rem_d;
      o_data        <= data_d;
      o_valid       <= valid_d;
      o_done        <= done_d;
      o_overrun_cnt <= ovr_d;
      o_adc_rst     <= (state_d == S_OFF);
      o_adc_ready   <= (state_d inside {S_IDLE, S_CAPTURE, S_DRAIN});
      o_busy        <= (state_d inside {S_CAPTURE, S_DRAIN});
    end
  end

endmodule

// File: tb/tb_ltc1406_capture_ctrl.sv
// Bench for ltc1406_capture_ctrl: phase-level behavioural model compared every
// cycle, a sample scoreboard, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_ltc1406_capture_ctrl;
  localparam int ENOB = 7;
  localparam int WAKE_CYCLES = 8;
  localparam int SETTLE_SAMPLES = 2;
  localparam int LEN_W = 16;

  localparam int P_OFF = 0, P_WAKE = 1, P_SETTLE = 2, P_IDLE = 3, P_CAP = 4, P_DRAIN = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             adc_dv = 1'b0;
  logic             start = 1'b0;
  logic             ready = 1'b0;
  logic [ENOB-1:0]  adc_data = '0;
  logic [LEN_W-1:0] len = '0;
  logic             adc_rst, valid, adc_ready, busy, done;
  logic [ENOB-1:0]  data;
  logic [7:0]       ovr;
  logic [2:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  logic [ENOB-1:0] exp_q[$];
  logic [ENOB-1:0] got_q[$];

  // Model state
  int              m_phase = P_OFF;
  int              m_wake_left = 0;
  int              m_settle_left = 0;
  int              m_rem = 0;
  int              m_ovr = 0;
  bit              m_valid = 1'b0;
  bit              m_done = 1'b0;
  logic [ENOB-1:0] m_data = '0;

  always #12.5 clk = ~clk;

  ltc1406_capture_ctrl #(
    .ENOB(ENOB), .WAKE_CYCLES(WAKE_CYCLES), .SETTLE_SAMPLES(SETTLE_SAMPLES), .LEN_W(LEN_W)
  ) dut (
    .i_sysclk_40(clk), .i_rst_n(rst_n), .i_enable(enable), .o_adc_rst(adc_rst),
    .i_adc_data(adc_data), .i_adc_dv(adc_dv), .i_start(start), .i_len(len),
    .o_data(data), .o_valid(valid), .i_ready(ready), .o_adc_ready(adc_ready),
    .o_busy(busy), .o_done(done), .o_overrun_cnt(ovr), .o_dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: phase-level description of the controller's rules.
  always @(posedge clk) begin : model
    bit hs;
    hs = m_valid && ready;
    if (!rst_n) begin
      m_phase = P_OFF; m_valid = 0; m_done = 0; m_data = '0; m_ovr = 0; m_rem = 0;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (m_phase != P_OFF && !enable) begin
        m_phase = P_OFF;
        m_valid = 0;
        exp_q.delete();
      end else begin
        case (m_phase)
          P_OFF: if (enable) begin m_phase = P_WAKE; m_wake_left = WAKE_CYCLES; end
          P_WAKE: begin
            m_wake_left--;
            if (m_wake_left == 0) begin
              if (SETTLE_SAMPLES == 0) m_phase = P_IDLE;
              else begin m_phase = P_SETTLE; m_settle_left = SETTLE_SAMPLES; end
            end
          end
          P_SETTLE: if (adc_dv) begin
            m_settle_left--;
            if (m_settle_left == 0) m_phase = P_IDLE;
          end
          P_IDLE: if (start) begin
            if (len == 0) m_done = 1;
            else begin m_phase = P_CAP; m_rem = int'(len); m_ovr = 0; end
          end
          P_CAP: begin
            if (adc_dv) begin
              m_rem--;
              if (!m_valid || hs) begin
                m_data = adc_data;
                m_valid = 1;
                exp_q.push_back(adc_data);
              end else if (m_ovr < 255) begin
                m_ovr++;
              end
              if (m_rem == 0) m_phase = P_DRAIN;
            end else if (hs) begin
              m_valid = 0;
            end
          end
          P_DRAIN: if (!m_valid || hs) begin
            m_done = 1; m_valid = 0; m_phase = P_IDLE;
          end
          default: m_phase = P_OFF;
        endcase
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("adc_rst", 32'(adc_rst), 32'(m_phase == P_OFF));
      chk("adc_ready", 32'(adc_ready), 32'(m_phase == P_IDLE || m_phase == P_CAP || m_phase == P_DRAIN));
      chk("busy", 32'(busy), 32'(m_phase == P_CAP || m_phase == P_DRAIN));
      chk("done", 32'(done), 32'(m_done));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("overrun_cnt", 32'(ovr), 32'(m_ovr));
      if (m_valid) chk("data", 32'(data), 32'(m_data));
      if (valid === 1'b1 && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: handshake carried 0x%0h but no sample was expected", data);
        end else begin
          chk("sb_data", 32'(data), 32'(exp_q.pop_front()));
        end
        got_q.push_back(data);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic pulse(input logic [ENOB-1:0] first, input logic [ENOB-1:0] step,
                       input int n, input int gap);
    logic [ENOB-1:0] d;
    d = first;
    for (int i = 0; i < n; i++) begin
      adc_data = d;
      adc_dv = 1'b1;
      tick();
      adc_dv = 1'b0;
      repeat (gap) tick();
      d = d + step;
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin seen = 1; break; end
      tick();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic burst_start(input logic [LEN_W-1:0] n);
    start = 1'b1;
    len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic power_up(input string tag);
    chk({tag, "_pre_adc_rst"}, 32'(adc_rst), 32'd1);
    enable = 1'b1;
    tick();
    chk({tag, "_adc_rst_fall"}, 32'(adc_rst), 32'd0);
    pulse(7'h78, 7'h01, 4, 1);
    chk({tag, "_wake_not_ready"}, 32'(adc_ready), 32'd0);
    adc_data = 7'h01; adc_dv = 1'b1; tick(); adc_dv = 1'b0;
    chk({tag, "_settle1_not_ready"}, 32'(adc_ready), 32'd0);
    tick();
    adc_data = 7'h02; adc_dv = 1'b1; tick(); adc_dv = 1'b0;
    chk({tag, "_settle2_ready"}, 32'(adc_ready), 32'd1);
    chk({tag, "_no_valid"}, 32'(valid), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int d0;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_adc_rst", 32'(adc_rst), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_ready", 32'(adc_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: power-up
    power_up("t1");

    // 2: simple burst
    ready = 1'b1;
    got_q.delete();
    d0 = done_cnt;
    burst_start(16'd3);
    chk("t2_busy", 32'(busy), 32'd1);
    pulse(7'h11, 7'h11, 3, 1);
    wait_done("t2_done", 10);
    tick();
    chk("t2_beats", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("t2_beat0", 32'(got_q[0]), 32'h11);
      chk("t2_beat1", 32'(got_q[1]), 32'h22);
      chk("t2_beat2", 32'(got_q[2]), 32'h33);
    end
    chk("t2_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t2_ovr", 32'(ovr), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // 3: backpressure
    ready = 1'b0;
    got_q.delete();
    burst_start(16'd4);
    pulse(7'h40, 7'h01, 4, 1);
    chk("t3_held_data", 32'(data), 32'h40);
    chk("t3_ovr", 32'(ovr), 32'd3);
    chk("t3_valid", 32'(valid), 32'd1);
    chk("t3_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    wait_done("t3_done", 10);
    tick();
    chk("t3_beats", 32'(got_q.size()), 32'd1);
    chk("t3_ovr_kept", 32'(ovr), 32'd3);

    // 4: disable mid-burst
    d0 = done_cnt;
    burst_start(16'd5);
    pulse(7'h50, 7'h01, 2, 1);
    enable = 1'b0;
    tick();
    chk("t4_adc_rst", 32'(adc_rst), 32'd1);
    chk("t4_valid", 32'(valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    repeat (4) tick();
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    power_up("t4");

    // 5: corner starts
    burst_start(16'd0);
    chk("t5_zero_done", 32'(done), 32'd1);
    chk("t5_zero_valid", 32'(valid), 32'd0);
    tick();
    chk("t5_zero_done_end", 32'(done), 32'd0);
    got_q.delete();
    burst_start(16'd2);
    burst_start(16'd7);
    pulse(7'h61, 7'h01, 2, 1);
    wait_done("t5_done", 6);
    tick();
    chk("t5_beats", 32'(got_q.size()), 32'd2);

    // 6: reset mid-capture
    d0 = done_cnt;
    burst_start(16'd4);
    pulse(7'h70, 7'h01, 1, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_adc_rst", 32'(adc_rst), 32'd1);
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_data", 32'(data), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(adc_ready), 32'd0);
    chk("t6_state", 32'(dbg_state), 32'd0);
    repeat (5) tick();
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
